tick_timer: RTL and testbench

//  Parametrised game timer for the typing tutor: prescales clk into ticks and keeps a

---
 rtl/tick_timer_if.sv | 26 ++
 rtl/tick_timer.sv | 119 +++++++++++
 tb/tb_tick_timer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/tick_timer_if.sv
// Command/status bundle between the round controller (master) and tick_timer (slave).
interface tick_timer_if #(
  parameter int TIME_W = 8
);
  logic              start;
  logic              pause;
  logic              resume;
  logic              count_down;
  logic [TIME_W-1:0] load_val;
  logic [TIME_W-1:0] cur_time;
  logic              tick;
  logic              running;
  logic              paused;
  logic              done;
  logic              expired;

  modport master (
    output start, pause, resume, count_down, load_val,
    input  cur_time, tick, running, paused, done, expired
  );

  modport slave (
    input  start, pause, resume, count_down, load_val,
    output cur_time, tick, running, paused, done, expired
  );
endinterface

// File: rtl/tick_timer.sv
// Game timer: prescales clk into ticks and counts time up to MAX_TIME or down to 0.
//   state   | meaning
//   S_IDLE  | after reset, waiting for start
//   S_RUN   | prescaler active, time updates on each tick
//   S_PAUSE | prescaler and time frozen until resume
//   S_DONE  | terminal value reached, held until start
module tick_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int TIME_W   = 8,
  parameter int MAX_TIME = 2**TIME_W - 1
) (
  input  logic        clk,
  input  logic        reset,
  tick_timer_if.slave bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_LOAD = PW'(TICK_DIV - 1);
  localparam logic [TIME_W-1:0] MAX_T      = TIME_W'(MAX_TIME);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [PW-1:0]     presc, presc_n;
  logic [TIME_W-1:0] cur_time, time_n;
  logic              mode_down, mode_n;
  logic              tick_r, tick_n;
  logic              exp_r, exp_n;

  logic [TIME_W-1:0] time_step;
  logic              at_term;
  logic              pause_only;
  logic              resume_only;

  // Prescaler is a down-counter: a tick fires when it reaches zero.
  assign time_step   = mode_down ? (cur_time - TIME_W'(1)) : (cur_time + TIME_W'(1));
  assign at_term     = mode_down ? (time_step == '0) : (time_step == MAX_T);
  assign pause_only  = bus.pause & ~bus.resume;
  assign resume_only = bus.resume & ~bus.pause;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      presc     <= '0;
      cur_time  <= '0;
      mode_down <= 1'b0;
      tick_r    <= 1'b0;
      exp_r     <= 1'b0;
    end else begin
      state     <= state_n;
      presc     <= presc_n;
      cur_time  <= time_n;
      mode_down <= mode_n;
      tick_r    <= tick_n;
      exp_r     <= exp_n;
    end
  end

  always_comb begin
    state_n = state;
    presc_n = presc;
    time_n  = cur_time;
    mode_n  = mode_down;
    tick_n  = 1'b0;
    exp_n   = 1'b0;
    if (bus.start) begin
      mode_n  = bus.count_down;
      presc_n = PRESC_LOAD;
      if (bus.count_down && (bus.load_val == '0)) begin
        state_n = S_DONE;
        time_n  = '0;
        presc_n = '0;
        exp_n   = 1'b1;
      end else begin
        state_n = S_RUN;
        time_n  = bus.count_down ? bus.load_val : '0;
      end
    end else begin
      unique case (state)
        S_RUN: begin
          if (presc == '0) begin
            // A pause on the wrap edge still lets this update through.
            tick_n  = 1'b1;
            time_n  = time_step;
            presc_n = PRESC_LOAD;
            if (at_term) begin
              state_n = S_DONE;
              presc_n = '0;
              exp_n   = 1'b1;
            end else if (pause_only) begin
              state_n = S_PAUSE;
            end
          end else if (pause_only) begin
            state_n = S_PAUSE;
          end else begin
            presc_n = presc - PW'(1);
          end
        end
        S_PAUSE: begin
          if (resume_only) state_n = S_RUN;
        end
        default: ;
      endcase
    end
  end

  assign bus.cur_time = cur_time;
  assign bus.tick     = tick_r;
  assign bus.expired  = exp_r;
  assign bus.running  = (state == S_RUN);
  assign bus.paused   = (state == S_PAUSE);
  assign bus.done     = (state == S_DONE);

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: directed scenarios plus random commands against a cycle-level reference model.
module tb_tick_timer;
  localparam int TD = 4;
  localparam int TW = 4;
  localparam int MT = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tick_timer_if #(.TIME_W(TW)) tif();

  tick_timer #(.TICK_DIV(TD), .TIME_W(TW), .MAX_TIME(MT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (tif)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase = RUN cycles elapsed since the last tick or start.
  int m_state = 0;  // 0 idle, 1 run, 2 pause, 3 done
  int m_time = 0;
  int m_phase = 0;
  bit m_down = 0;
  bit m_tick = 0;
  bit m_exp = 0;

  bit       cd_v = 0;
  bit [3:0] lv_v = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_step(input bit rs, input bit st, input bit pa, input bit re,
                            input bit cd, input int lv);
    if (rs) begin
      m_state = 0; m_time = 0; m_phase = 0; m_down = 0; m_tick = 0; m_exp = 0;
      return;
    end
    m_tick = 0;
    m_exp  = 0;
    if (st) begin
      m_down  = cd;
      m_phase = 0;
      if (cd && lv == 0) begin
        m_state = 3; m_time = 0; m_exp = 1;
      end else begin
        m_state = 1; m_time = cd ? lv : 0;
      end
    end else if (m_state == 1) begin
      if (m_phase == TD - 1) begin
        m_phase = 0;
        m_tick  = 1;
        m_time  = m_down ? m_time - 1 : m_time + 1;
        if ((m_down && m_time == 0) || (!m_down && m_time == MT)) begin
          m_state = 3; m_exp = 1;
        end else if (pa && !re) begin
          m_state = 2;
        end
      end else if (pa && !re) begin
        m_state = 2;
      end else begin
        m_phase++;
      end
    end else if (m_state == 2 && re && !pa) begin
      m_state = 1;
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {7'd0, tif.cur_time, tif.tick, tif.running, tif.paused, tif.done, tif.expired};
  endfunction

  function automatic logic [15:0] model_vec();
    return {7'd0, 4'(m_time), m_tick, m_state == 1, m_state == 2, m_state == 3, m_exp};
  endfunction

  task automatic cyc(input bit st, input bit pa, input bit re, input bit rs);
    tif.start      = st;
    tif.pause      = pa;
    tif.resume     = re;
    tif.count_down = cd_v;
    tif.load_val   = lv_v;
    reset          = rs;
    @(posedge clk);
    model_step(rs, st, pa, re, cd_v, int'(lv_v));
    @(negedge clk);
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int ticks;
    int exps;
    bit found;

    tif.start = 0; tif.pause = 0; tif.resume = 0; tif.count_down = 0; tif.load_val = 0;
    reset = 1;
    @(negedge clk);

    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("reset_outs", dut_vec(), 16'h0000);

    // Up run to MAX_TIME, then hold for 20+ cycles.
    cd_v = 0; lv_v = 4'd7;
    cyc(1, 0, 0, 0);
    ticks = 0; exps = 0;
    for (int i = 0; i < 44; i++) begin
      cyc(0, 0, 0, 0);
      ticks += int'(tif.tick);
      exps  += int'(tif.expired);
    end
    check("up_ticks", 16'(ticks), 16'd5);
    check("up_expired", 16'(exps), 16'd1);
    check("up_hold_time", 16'(tif.cur_time), 16'd5);
    check("up_done", 16'(tif.done), 16'd1);

    // Down run from 3.
    cd_v = 1; lv_v = 4'd3;
    cyc(1, 0, 0, 0);
    idle(12);
    check("down_time", 16'(tif.cur_time), 16'd0);
    check("down_done", 16'(tif.done), 16'd1);

    // Down from 0: immediate expiry, never a tick.
    lv_v = 4'd0;
    cyc(1, 0, 0, 0);
    check("load0_done_exp", {14'd0, tif.done, tif.expired}, 16'd3);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      ticks += int'(tif.tick);
    end
    check("load0_ticks", 16'(ticks), 16'd0);

    // Pause two cycles after a tick, hold, resume.
    cd_v = 0;
    cyc(1, 0, 0, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (tif.tick) found = 1;
    end
    check("wait_tick", 16'(found), 16'd1);
    idle(2);
    cyc(0, 1, 0, 0);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0);
      ticks += int'(tif.tick);
    end
    check("pause_ticks", 16'(ticks), 16'd0);
    check("pause_frozen", {11'd0, tif.cur_time, tif.paused}, {11'd0, 4'd1, 1'b1});
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    check("resume_no_early_tick", 16'(tif.tick), 16'd0);
    cyc(0, 0, 0, 0);
    check("resume_tick", {11'd0, tif.cur_time, tif.tick}, {11'd0, 4'd2, 1'b1});

    // Restart at cur_time 3, then pause, pause+resume, reset.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc(0, 0, 0, 0);
      if (tif.cur_time == 4'd3) found = 1;
    end
    check("wait_time3", 16'(found), 16'd1);
    cyc(1, 0, 0, 0);
    check("restart", {11'd0, tif.cur_time, tif.running}, {11'd0, 4'd0, 1'b1});
    idle(2);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    check("both_in_pause", 16'(tif.paused), 16'd1);
    cyc(0, 0, 0, 1);
    check("reset_in_pause", dut_vec(), 16'h0000);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    check("both_in_run", {14'd0, tif.running, tif.paused}, 16'd2);

    // Mode latched at start; count_down toggles mid-run are ignored.
    cd_v = 1; lv_v = 4'd9;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cd_v = ~cd_v;
      lv_v = 4'($urandom_range(0, 15));
      cyc(0, 0, 0, 0);
    end
    check("mode_latch", 16'(tif.cur_time), 16'd4);

    // Random commands against the model.
    for (int i = 0; i < 3000; i++) begin
      cd_v = 1'($urandom_range(0, 1));
      lv_v = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
